// File: rtl/uart_byte_rx_if.sv
// Connection between the UART byte receiver and whatever drives its line and
// consumes its received bytes, done/error pulses and busy flag.
interface uart_byte_rx_if #(
  parameter int DATA_BIT = 8
);
  logic                i_rx;
  logic [DATA_BIT-1:0] o_data;
  logic                o_rx_done_tick;
  logic                o_frame_err;
  logic                o_busy;

  // master: line driver / byte consumer; slave: the receiver itself
  modport master (
    output i_rx,
    input  o_data, o_rx_done_tick, o_frame_err, o_busy
  );
  modport slave (
    input  i_rx,
    output o_data, o_rx_done_tick, o_frame_err, o_busy
  );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver, LSB first, 16x oversampling from an internal baud divider.
// Good bytes are forwarded with a one-clk done pulse; bad stop bits only pulse frame_err.
module uart_byte_rx #(
  parameter int DATA_BIT = 8,
  parameter int CLK_DIV  = 27
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_byte_rx_if.slave  bus
);
  localparam int              NW       = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
  localparam logic [15:0]     DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [NW-1:0]   N_LAST   = NW'(DATA_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t              state_reg, state_next;
  logic [1:0]          sync_reg;
  logic                rx_s;
  logic [15:0]         div_reg, div_next;
  logic                tick;
  logic                start_detect;
  logic [3:0]          s_reg, s_next;
  logic [NW-1:0]       n_reg, n_next;
  logic [DATA_BIT-1:0] b_reg, b_next;
  logic [DATA_BIT-1:0] data_reg, data_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;
  logic                stop_sample;

  // Two-flop synchronizer; idles at 1 so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (!rst_n) sync_reg <= 2'b11;
    else        sync_reg <= {sync_reg[0], bus.i_rx};
  end
  assign rx_s = sync_reg[1];

  // Oversample tick divider, re-phased at start detection so samples land mid-bit
  assign start_detect = (state_reg == S_IDLE) && !rx_s;
  assign tick         = (div_reg == DIV_LAST);

  always_comb begin
    div_next = tick ? 16'd0 : div_reg + 16'd1;
    if (start_detect) div_next = 16'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) div_reg <= 16'd0;
    else        div_reg <= div_next;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      s_reg     <= 4'd0;
      n_reg     <= '0;
      b_reg     <= '0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    case (state_reg)
      S_IDLE: begin
        if (!rx_s) begin
          state_next = S_START;
          s_next     = 4'd0;
        end
      end
      S_START: begin
        if (tick) begin
          if (s_reg == 4'd7) begin
            if (!rx_s) begin
              state_next = S_DATA;
              s_next     = 4'd0;
              n_next     = '0;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (s_reg == 4'd15) begin
            s_next = 4'd0;
            b_next = {rx_s, b_reg[DATA_BIT-1:1]};
            if (n_reg == N_LAST) state_next = S_STOP;
            else                 n_next     = n_reg + 1'b1;
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (s_reg == 4'd15) state_next = S_IDLE;
          else                s_next     = s_reg + 4'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode: the mid-stop sample decides between done and frame error
  always_comb begin
    stop_sample = (state_reg == S_STOP) && tick && (s_reg == 4'd15);
    done_next   = stop_sample && rx_s;
    err_next    = stop_sample && !rx_s;
    data_next   = done_next ? b_reg : data_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_reg <= '0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      data_reg <= data_next;
      done_reg <= done_next;
      err_reg  <= err_next;
    end
  end

  assign bus.o_data         = data_reg;
  assign bus.o_rx_done_tick = done_reg;
  assign bus.o_frame_err    = err_reg;
  assign bus.o_busy         = (state_reg != S_IDLE);
endmodule
